spi_slave: RTL

- SPI slave (mode 0: CPOL=0, CPHA=0; MSB first; 8-bit frames) for the far end of the team's SPI master.
- Oversamples the external sck, ss_n and mosi pins with clk, using a synchronizer chain.
- Shifts received bits into a byte, presenting it with a one-cycle new_data strobe, and simultaneously shifts out a byte on miso.
- Supports back-to-back bytes while ss_n stays low. Sits between the pad ring and the user logic.

---
 rtl/spi_slave.sv | 115 +++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// Mode-0 SPI slave, MSB first, 8-bit frames. The pins are oversampled with clk through
// synchronizer chains, and back-to-back bytes are supported while ss_n stays low.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss_n,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    output logic       tx_taken,
    output logic [7:0] data_out,
    output logic       new_data,
    output logic       busy
);

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_sync_vld;
    logic                   r_sck_prev;
    logic                   r_ss_prev;
    logic                   r_armed;
    logic [2:0]             r_bit_ctr;
    logic [7:0]             r_rx_shift;
    logic [7:0]             r_tx_shift;
    logic [7:0]             r_data_out;
    logic                   r_new_data;
    logic                   r_tx_taken;

    logic       w_sck_s;
    logic       w_ss_s;
    logic       w_mosi_s;
    logic       w_sel;
    logic       w_sel_start;
    logic       w_sck_rise;
    logic       w_sck_fall;
    logic [7:0] w_rx_next;

    assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
    assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    // After reset the select is only honoured once ss_n has been seen high on the pin,
    // so a transfer already in flight is ignored until a fresh ss_n fall.
    assign w_sel       = r_armed & ~w_ss_s;
    assign w_sel_start = w_sel & r_ss_prev;
    assign w_sck_rise  = w_sck_s & ~r_sck_prev;
    assign w_sck_fall  = ~w_sck_s & r_sck_prev;
    assign w_rx_next   = {r_rx_shift[6:0], w_mosi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_sync  <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sync_vld  <= '0;
            r_sck_prev  <= 1'b0;
            r_ss_prev   <= 1'b1;
            r_armed     <= 1'b0;
            r_bit_ctr   <= 3'd0;
            r_rx_shift  <= 8'h00;
            r_tx_shift  <= 8'h00;
            r_data_out  <= 8'h00;
            r_new_data  <= 1'b0;
            r_tx_taken  <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sync_vld  <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
            r_sck_prev  <= w_sck_s;
            r_ss_prev   <= w_ss_s;
            r_armed     <= r_armed | (r_sync_vld[SYNC_STAGES-1] & w_ss_s);
            r_new_data  <= 1'b0;
            r_tx_taken  <= 1'b0;

            if (!w_sel) begin
                r_bit_ctr  <= 3'd0;
                r_rx_shift <= 8'h00;
            end else if (w_sel_start) begin
                r_tx_shift <= tx_data;
                r_tx_taken <= 1'b1;
                r_bit_ctr  <= 3'd0;
                r_rx_shift <= 8'h00;
            end else if (w_sck_rise) begin
                r_rx_shift <= w_rx_next;
                r_bit_ctr  <= r_bit_ctr + 3'd1;
                if (r_bit_ctr == 3'd7) begin
                    r_data_out <= w_rx_next;
                    r_new_data <= 1'b1;
                end
            end else if (w_sck_fall) begin
                // A fall with the counter back at zero ends a byte: preload the next one.
                if (r_bit_ctr == 3'd0) begin
                    r_tx_shift <= tx_data;
                    r_tx_taken <= 1'b1;
                end else begin
                    r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                end
            end
        end
    end

    assign miso     = w_sel & r_tx_shift[7];
    assign miso_oe  = w_sel;
    assign tx_taken = r_tx_taken;
    assign data_out = r_data_out;
    assign new_data = r_new_data;
    assign busy     = w_sel & (r_bit_ctr != 3'd0);

endmodule
